// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared lane ids, rwe encodings and engine states for the memory responder
package mem_resp_pkg;

  localparam logic LANE_I = 1'b1;
  localparam logic LANE_D = 1'b0;

  localparam logic [1:0] RWE_READ  = 2'b01;
  localparam logic [1:0] RWE_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } engine_state_e;

  // rwe=11 counts as a write
  function automatic logic is_write(input logic [1:0] rwe);
    return (rwe & RWE_WRITE) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_sp_array.sv
// rtl/mem_sp_array.sv - single-port DEPTH x 32 word array with byte write enables and registered read
module mem_sp_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dual_port_mem_responder.sv
// rtl/dual_port_mem_responder.sv - two-lane memory responder arbitrating onto one single-port array
// Optional MEM_OOR_ERR_EN adds mem_err_o and blocks accesses at or above DEPTH*4.
module dual_port_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_rwe_i,
  input  logic [63:0] mem_addr_i,
  input  logic [7:0]  mem_sel_i,
  input  logic [63:0] mem_data_i,
  output logic [63:0] mem_data_o,
  output logic [1:0]  mem_busy_o,
  output logic [1:0]  mem_done_o
`ifdef MEM_OOR_ERR_EN
  ,
  output logic [1:0]  mem_err_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  engine_state_e state_q;
  logic          gnt_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    busy_q, done_q, wr_q, acc, pend;
  logic [31:0]   addr_q [2];
  logic [31:0]   wdata_q [2];
  logic [3:0]    sel_q [2];
  logic [31:0]   hold_q [2];

  logic          cur_lane, cur_wr, grant, do_access, cur_oor;
  logic [31:0]   cur_addr, cur_data, rd_word, arr_rdata;
  logic [3:0]    cur_sel;
  logic          unused_addr_bits;

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      acc[l] = (mem_rwe_i[2*l +: 2] != 2'b00) && !busy_q[l] && !done_q[l];
    end
  end

  // In IDLE every busy lane is waiting; a same-edge request joins arbitration directly
  assign pend     = busy_q | acc;
  assign grant    = (state_q == IDLE) && (pend != 2'b00);
  assign cur_lane = (state_q == IDLE) ? (pend[LANE_D] ? LANE_D : LANE_I) : gnt_q;

  always_comb begin
    cur_addr = addr_q[cur_lane];
    cur_data = wdata_q[cur_lane];
    cur_sel  = sel_q[cur_lane];
    cur_wr   = wr_q[cur_lane];
    if (state_q == IDLE && acc[cur_lane]) begin
      cur_addr = cur_lane ? mem_addr_i[63:32] : mem_addr_i[31:0];
      cur_data = cur_lane ? mem_data_i[63:32] : mem_data_i[31:0];
      cur_sel  = cur_lane ? mem_sel_i[7:4]    : mem_sel_i[3:0];
      cur_wr   = is_write(cur_lane ? mem_rwe_i[3:2] : mem_rwe_i[1:0]);
    end
  end

  // The grant edge is the first count edge, so LATENCY=1 accesses at the grant itself
  assign do_access = (state_q == ACCESS && cnt_q == '0) || (grant && LATENCY == 1);
  assign unused_addr_bits = ^{cur_addr[31:AW+2], cur_addr[1:0]};

`ifdef MEM_OOR_ERR_EN
  logic err_q;
  assign cur_oor   = cur_addr >= 32'(DEPTH * 4);
  assign rd_word   = err_q ? 32'h0 : arr_rdata;
  assign mem_err_o = done_q & {2{err_q}};
`else
  assign cur_oor   = 1'b0;
  assign rd_word   = arr_rdata;
`endif

  mem_sp_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .en    (do_access && !rst && !cur_oor),
    .we    (cur_wr ? cur_sel : 4'b0000),
    .addr  (cur_addr[2 +: AW]),
    .wdata (cur_data),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= LANE_D;
      cnt_q     <= '0;
      busy_q    <= '0;
      done_q    <= '0;
      hold_q[0] <= '0;
      hold_q[1] <= '0;
`ifdef MEM_OOR_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      for (int l = 0; l < 2; l++) begin
        if (done_q[l] && !wr_q[l]) hold_q[l] <= rd_word;
        if (acc[l]) begin
          busy_q[l]  <= 1'b1;
          addr_q[l]  <= mem_addr_i[32*l +: 32];
          wdata_q[l] <= mem_data_i[32*l +: 32];
          sel_q[l]   <= mem_sel_i[4*l +: 4];
          wr_q[l]    <= is_write(mem_rwe_i[2*l +: 2]);
        end
      end
      case (state_q)
        IDLE: begin
          if (grant) begin
            gnt_q   <= cur_lane;
            state_q <= ACCESS;
            cnt_q   <= CW'(LATENCY - 2);
          end
        end
        ACCESS:  if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (do_access) begin
        state_q          <= DONE;
        busy_q[cur_lane] <= 1'b0;
        done_q[cur_lane] <= 1'b1;
`ifdef MEM_OOR_ERR_EN
        err_q            <= cur_oor;
`endif
      end
    end
  end

  assign mem_busy_o = busy_q;
  assign mem_done_o = done_q;
  assign mem_data_o[31:0]  = (done_q[0] && !wr_q[0]) ? rd_word : hold_q[0];
  assign mem_data_o[63:32] = (done_q[1] && !wr_q[1]) ? rd_word : hold_q[1];

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// tb/tb_dual_port_mem_responder.sv - directed self-checking bench for dual_port_mem_responder
module tb_dual_port_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mem_rwe_i;
  logic [63:0] mem_addr_i;
  logic [7:0]  mem_sel_i;
  logic [63:0] mem_data_i;
  logic [63:0] mem_data_o;
  logic [1:0]  mem_busy_o;
  logic [1:0]  mem_done_o;
`ifdef MEM_OOR_ERR_EN
  logic [1:0]  mem_err_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic last_err;

  dual_port_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rwe_i  (mem_rwe_i),
    .mem_addr_i (mem_addr_i),
    .mem_sel_i  (mem_sel_i),
    .mem_data_i (mem_data_i),
    .mem_data_o (mem_data_o),
    .mem_busy_o (mem_busy_o),
    .mem_done_o (mem_done_o)
`ifdef MEM_OOR_ERR_EN
    ,
    .mem_err_o  (mem_err_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic do_op(input int lane, input logic [1:0] rwe, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] data,
                       output logic [31:0] rd, output int n);
    mem_rwe_i[2*lane +: 2]   = rwe;
    mem_addr_i[32*lane +: 32] = addr;
    mem_sel_i[4*lane +: 4]   = sel;
    mem_data_i[32*lane +: 32] = data;
    @(posedge clk);
    n = 0;
    rd = '0;
    last_err = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) mem_rwe_i = '0;
      if (n == 1 && !mem_done_o[lane]) check("busy_after_accept", 64'(mem_busy_o[lane]), 64'd1);
      if (mem_done_o[lane]) begin
        rd = mem_data_o[32*lane +: 32];
        check("busy_clear_on_done", 64'(mem_busy_o[lane]), 64'd0);
`ifdef MEM_OOR_ERR_EN
        last_err = mem_err_o[lane];
`endif
        break;
      end
    end
    @(negedge clk);
  endtask

  logic [31:0] rd, lo, hi;
  int n, d0, d1;
  logic b1;

  initial begin
    rst = 1'b1;
    mem_rwe_i = 4'b0101;
    mem_addr_i = '0;
    mem_sel_i = '0;
    mem_data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(mem_busy_o), 64'd0);
    check("reset_done", 64'(mem_done_o), 64'd0);
    check("reset_data", mem_data_o, 64'd0);
    rst = 1'b0;
    mem_rwe_i = '0;
    @(negedge clk);
    check("no_latch_in_reset", 64'(mem_busy_o), 64'd0);

    do_op(0, 2'b10, 32'h10, 4'hF, 32'hDEADBEEF, rd, n);
    check("wr_latency", 64'(n), 64'd2);
    do_op(0, 2'b01, 32'h10, 4'h0, 32'h0, rd, n);
    check("rd_latency", 64'(n), 64'd2);
    check("rd_data", 64'(rd), 64'hDEADBEEF);
    do_op(0, 2'b10, 32'h10, 4'b0001, 32'h00000011, rd, n);
    check("wr_keeps_data_o", 64'(rd), 64'hDEADBEEF);
    do_op(0, 2'b01, 32'h10, 4'h0, 32'h0, rd, n);
    check("byte_enable", 64'(rd), 64'hDEADBE11);
    do_op(0, 2'b10, 32'h14, 4'hF, 32'h0BADF00D, rd, n);

    // both lanes request in the same cycle
    mem_rwe_i = 4'b0101;
    mem_addr_i = {32'h10, 32'h14};
    @(posedge clk);
    n = 0; d0 = 0; d1 = 0; lo = '0; hi = '0; b1 = 1'b0;
    while (n < 20 && d1 == 0) begin
      @(negedge clk);
      n++;
      if (n == 1) mem_rwe_i = '0;
      if (mem_done_o[0] && d0 == 0) begin
        d0 = n; lo = mem_data_o[31:0]; b1 = mem_busy_o[1];
      end
      if (mem_done_o[1]) begin
        d1 = n; hi = mem_data_o[63:32];
      end
    end
    @(negedge clk);
    check("arb_lane0_first", 64'(d0), 64'd2);
    check("arb_lane0_data", 64'(lo), 64'h0BADF00D);
    check("arb_lane1_waits_busy", 64'(b1), 64'd1);
    check("arb_lane1_latency", 64'(d1), 64'd5);
    check("arb_lane1_data", 64'(hi), 64'hDEADBE11);
    check("lane0_data_held", 64'(mem_data_o[31:0]), 64'h0BADF00D);

    // a write presented while lane 0 is busy must be dropped
    mem_rwe_i[1:0] = 2'b01;
    mem_addr_i[31:0] = 32'h10;
    @(posedge clk);
    @(negedge clk);
    mem_rwe_i[1:0] = 2'b10;
    mem_sel_i[3:0] = 4'hF;
    mem_data_i[31:0] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    check("busy_op_done", 64'(mem_done_o[0]), 64'd1);
    mem_rwe_i = '0;
    @(negedge clk);
    check("busy_rwe_ignored", 64'(mem_busy_o), 64'd0);
    do_op(0, 2'b01, 32'h10, 4'h0, 32'h0, rd, n);
    check("busy_write_dropped", 64'(rd), 64'hDEADBE11);

    do_op(1, 2'b11, 32'h24, 4'hF, 32'hA5A5A5A5, rd, n);
    check("lane1_wr_latency", 64'(n), 64'd2);
    do_op(1, 2'b01, 32'h24, 4'h0, 32'h0, rd, n);
    check("rwe11_is_write", 64'(rd), 64'hA5A5A5A5);

    // reset lands on the write's commit edge
    do_op(0, 2'b10, 32'h20, 4'hF, 32'hCAFEF00D, rd, n);
    mem_rwe_i[1:0] = 2'b10;
    mem_addr_i[31:0] = 32'h20;
    mem_data_i[31:0] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    mem_rwe_i = '0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(mem_busy_o), 64'd0);
    check("abort_done", 64'(mem_done_o), 64'd0);
    check("abort_data_o", mem_data_o, 64'd0);
    @(negedge clk);
    do_op(0, 2'b01, 32'h20, 4'h0, 32'h0, rd, n);
    check("abort_no_write", 64'(rd), 64'hCAFEF00D);

    do_op(0, 2'b10, 32'h0, 4'hF, 32'h55AA55AA, rd, n);
    do_op(0, 2'b01, 32'h1000, 4'h0, 32'h0, rd, n);
    check("oor_latency", 64'(n), 64'd2);
`ifdef MEM_OOR_ERR_EN
    check("oor_err", 64'(last_err), 64'd1);
    check("oor_data", 64'(rd), 64'd0);
`else
    check("wrap_data", 64'(rd), 64'h55AA55AA);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
